ad80305_rx_dc_corr_td: RTL and testbench



---
 rtl/ad80305_pkg.sv | 23 ++
 rtl/ad80305_dc_est.sv | 87 ++++++++
 rtl/ad80305_rx_dc_corr_td.sv | 94 +++++++++
 tb/tb_ad80305_rx_dc_corr_td.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ad80305_pkg.sv
// Shared types, widths and helpers for the AD80305 receive DC-correction slice.
package ad80305_pkg;

  localparam int IQ_W      = 12;
  localparam int DC_CORR_W = 8;
  // Wide enough for the largest accumulator shift result (13 + 20 bits) plus sign.
  localparam int SAT_W     = IQ_W + 1 + 20 + 1;

  typedef logic signed [IQ_W-1:0] iq_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_UPDATE = 2'd2
  } est_state_e;

  function automatic iq_t sat12(input logic signed [SAT_W-1:0] x);
    if (x > SAT_W'(signed'(2047)))        return iq_t'(2047);
    else if (x < SAT_W'(signed'(-2048)))  return iq_t'(-2048);
    else                                  return iq_t'(x);
  endfunction

endpackage

// File: rtl/ad80305_dc_est.sv
// Block-averaging DC estimator shared by I and Q: IDLE/ACCUM/UPDATE FSM, counter,
// accumulators and the held estimate.
module ad80305_dc_est
  import ad80305_pkg::*;
#(
  parameter int P_AVG_LOG2 = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                strobe,
  input  logic                run,
  input  logic signed [IQ_W:0] s1_i,
  input  logic signed [IQ_W:0] s1_q,
  output iq_t                 est_i,
  output iq_t                 est_q,
  output logic                est_valid
);

  localparam int ACC_W = IQ_W + 1 + P_AVG_LOG2;
  localparam logic [P_AVG_LOG2-1:0] CNT_LAST = '1;

  est_state_e              state;
  logic [P_AVG_LOG2-1:0]   cnt;
  logic signed [ACC_W-1:0] acc_i, acc_q;
  logic signed [ACC_W-1:0] ext_i, ext_q;

  assign ext_i = ACC_W'(s1_i);
  assign ext_q = ACC_W'(s1_q);

  // NOTE: every register here uses <= so all updates see pre-edge values,
  // which is what lets UPDATE latch acc while simultaneously reloading it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      est_i     <= '0;
      est_q     <= '0;
      est_valid <= 1'b0;
    end else begin
      est_valid <= 1'b0;
      if (!run) begin
        // Losing enable (or entering bypass) drops the partial window; est is kept.
        state <= ST_IDLE;
        cnt   <= '0;
        acc_i <= '0;
        acc_q <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            cnt   <= '0;
            acc_i <= '0;
            acc_q <= '0;
            state <= ST_ACCUM;
          end
          ST_ACCUM: begin
            if (strobe) begin
              acc_i <= acc_i + ext_i;
              acc_q <= acc_q + ext_q;
              cnt   <= cnt + 1'b1;
              if (cnt == CNT_LAST) state <= ST_UPDATE;
            end
          end
          ST_UPDATE: begin
            est_i     <= sat12(SAT_W'(acc_i >>> P_AVG_LOG2));
            est_q     <= sat12(SAT_W'(acc_q >>> P_AVG_LOG2));
            est_valid <= 1'b1;
            // A strobe landing here opens the next window as its first sample.
            if (strobe) begin
              acc_i <= ext_i;
              acc_q <= ext_q;
              cnt   <= P_AVG_LOG2'(1);
            end else begin
              acc_i <= '0;
              acc_q <= '0;
              cnt   <= '0;
            end
            state <= ST_ACCUM;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ad80305_rx_dc_corr_td.sv
// Two-stage receive DC correction: static offset (stage 1), adaptive estimate with
// saturation or raw bypass (stage 2), plus the shared block-average estimator.
module ad80305_rx_dc_corr_td
  import ad80305_pkg::*;
#(
  parameter int P_AVG_LOG2 = 14
) (
  input  logic                 i_fpga_clk_125p,
  input  logic                 i_fpga_rst_n_125p,
  input  logic                 i_iqdata_fp,
  input  logic [IQ_W-1:0]      i_idata,
  input  logic [IQ_W-1:0]      i_qdata,
  input  logic                 i_iq_corr_bypass,
  input  logic [DC_CORR_W-1:0] i_dc_corr_idata,
  input  logic [DC_CORR_W-1:0] i_dc_corr_qdata,
  input  logic                 i_est_en,
  output logic                 o_iqdata_fp,
  output logic [IQ_W-1:0]      o_idata,
  output logic [IQ_W-1:0]      o_qdata,
  output logic [IQ_W-1:0]      o_dc_est_i,
  output logic [IQ_W-1:0]      o_dc_est_q,
  output logic                 o_est_valid,
  output logic                 o_sat
);

  logic signed [IQ_W:0]   s1_i_next, s1_q_next, s1_i, s1_q;
  logic [IQ_W-1:0]        raw_i, raw_q;
  logic                   v1, byp1;
  logic signed [IQ_W+1:0] diff_i, diff_q;
  iq_t                    corr_i, corr_q;
  logic                   clip_i, clip_q;

  // 13-bit difference of a 12-bit sample and an 8-bit offset cannot overflow.
  assign s1_i_next = (IQ_W+1)'(signed'(i_idata)) - (IQ_W+1)'(signed'(i_dc_corr_idata));
  assign s1_q_next = (IQ_W+1)'(signed'(i_qdata)) - (IQ_W+1)'(signed'(i_dc_corr_qdata));

  always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_n_125p) begin
    if (!i_fpga_rst_n_125p) begin
      v1    <= 1'b0;
      byp1  <= 1'b0;
      s1_i  <= '0;
      s1_q  <= '0;
      raw_i <= '0;
      raw_q <= '0;
    end else begin
      v1 <= i_iqdata_fp;
      if (i_iqdata_fp) begin
        byp1  <= i_iq_corr_bypass;
        s1_i  <= s1_i_next;
        s1_q  <= s1_q_next;
        raw_i <= i_idata;
        raw_q <= i_qdata;
      end
    end
  end

  assign diff_i = (IQ_W+2)'(s1_i) - (IQ_W+2)'(signed'(o_dc_est_i));
  assign diff_q = (IQ_W+2)'(s1_q) - (IQ_W+2)'(signed'(o_dc_est_q));
  assign corr_i = sat12(SAT_W'(diff_i));
  assign corr_q = sat12(SAT_W'(diff_q));
  assign clip_i = (diff_i > 14'sd2047) || (diff_i < -14'sd2048);
  assign clip_q = (diff_q > 14'sd2047) || (diff_q < -14'sd2048);

  always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_n_125p) begin
    if (!i_fpga_rst_n_125p) begin
      o_iqdata_fp <= 1'b0;
      o_idata     <= '0;
      o_qdata     <= '0;
      o_sat       <= 1'b0;
    end else begin
      o_iqdata_fp <= v1;
      o_sat       <= v1 && !byp1 && (clip_i || clip_q);
      if (v1) begin
        o_idata <= byp1 ? raw_i : corr_i;
        o_qdata <= byp1 ? raw_q : corr_q;
      end
    end
  end

  ad80305_dc_est #(
    .P_AVG_LOG2 (P_AVG_LOG2)
  ) u_dc_est (
    .clk       (i_fpga_clk_125p),
    .rst_n     (i_fpga_rst_n_125p),
    .strobe    (i_iqdata_fp),
    .run       (i_est_en && !i_iq_corr_bypass),
    .s1_i      (s1_i_next),
    .s1_q      (s1_q_next),
    .est_i     (o_dc_est_i),
    .est_q     (o_dc_est_q),
    .est_valid (o_est_valid)
  );

endmodule

// File: tb/tb_ad80305_rx_dc_corr_td.sv
// Self-checking bench: a queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_ad80305_rx_dc_corr_td;

  localparam int AVG_LOG2 = 4;
  localparam int WIN      = 1 << AVG_LOG2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strobe = 1'b0;
  logic [11:0] idata = '0, qdata = '0;
  logic        bypass = 1'b0;
  logic [7:0]  dci = '0, dcq = '0;
  logic        est_en = 1'b0;

  logic        o_fp, o_vld, o_sat;
  logic [11:0] o_i, o_q, o_est_i, o_est_q;

  int cur_i = 0, cur_q = 0, cur_dci = 0, cur_dcq = 0;
  int checks = 0, failures = 0, cyc = 0;
  int pulse_q[$];

  always #5 clk = ~clk;

  ad80305_rx_dc_corr_td #(.P_AVG_LOG2(AVG_LOG2)) dut (
    .i_fpga_clk_125p   (clk),
    .i_fpga_rst_n_125p (rst_n),
    .i_iqdata_fp       (strobe),
    .i_idata           (idata),
    .i_qdata           (qdata),
    .i_iq_corr_bypass  (bypass),
    .i_dc_corr_idata   (dci),
    .i_dc_corr_qdata   (dcq),
    .i_est_en          (est_en),
    .o_iqdata_fp       (o_fp),
    .o_idata           (o_i),
    .o_qdata           (o_q),
    .o_dc_est_i        (o_est_i),
    .o_dc_est_q        (o_est_q),
    .o_est_valid       (o_vld),
    .o_sat             (o_sat)
  );

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clamp12(input int x);
    if (x > 2047)  return 2047;
    if (x < -2048) return -2048;
    return x;
  endfunction

  function automatic int floor_avg(input int s[$]);
    int sum;
    sum = 0;
    foreach (s[k]) sum += s[k];
    return (sum >= 0) ? sum / WIN : -((-sum + WIN - 1) / WIN);
  endfunction

  // Reference model: a one-slot pipeline for the datapath and a sample queue per
  // channel for the window average.
  int m_fp = 0, m_i = 0, m_q = 0, m_sat = 0, m_est_i = 0, m_est_q = 0, m_vld = 0;
  int p_v = 0, p_byp = 0, p_s1_i = 0, p_s1_q = 0, p_raw_i = 0, p_raw_q = 0;
  bit running = 0, closing = 0;
  int win_i[$], win_q[$];

  always @(posedge clk or negedge rst_n) begin : model_step
    int s1i, s1q, di, dq;
    if (!rst_n) begin
      m_fp = 0; m_i = 0; m_q = 0; m_sat = 0; m_est_i = 0; m_est_q = 0; m_vld = 0;
      p_v = 0; p_byp = 0; p_s1_i = 0; p_s1_q = 0; p_raw_i = 0; p_raw_q = 0;
      running = 0; closing = 0;
      win_i.delete(); win_q.delete();
    end else begin
      s1i = cur_i - cur_dci;
      s1q = cur_q - cur_dcq;
      m_fp  = p_v;
      m_sat = 0;
      if (p_v != 0) begin
        if (p_byp != 0) begin
          m_i = p_raw_i; m_q = p_raw_q;
        end else begin
          di = p_s1_i - m_est_i; dq = p_s1_q - m_est_q;
          m_i = clamp12(di); m_q = clamp12(dq);
          m_sat = (m_i != di || m_q != dq) ? 1 : 0;
        end
      end
      p_v = strobe;
      if (strobe) begin
        p_s1_i = s1i; p_s1_q = s1q; p_raw_i = cur_i; p_raw_q = cur_q; p_byp = bypass;
      end
      m_vld = 0;
      if (!est_en || bypass) begin
        running = 0; closing = 0; win_i.delete(); win_q.delete();
      end else if (!running) begin
        running = 1;
      end else if (closing) begin
        m_est_i = clamp12(floor_avg(win_i));
        m_est_q = clamp12(floor_avg(win_q));
        m_vld = 1; closing = 0;
        win_i.delete(); win_q.delete();
        if (strobe) begin win_i.push_back(s1i); win_q.push_back(s1q); end
      end else if (strobe) begin
        win_i.push_back(s1i); win_q.push_back(s1q);
        if (win_i.size() == WIN) closing = 1;
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (o_vld === 1'b1) pulse_q.push_back(cyc);
    check("cyc_fp",    o_fp,              m_fp);
    check("cyc_idata", signed'(o_i),      m_i);
    check("cyc_qdata", signed'(o_q),      m_q);
    check("cyc_sat",   o_sat,             m_sat);
    check("cyc_est_i", signed'(o_est_i),  m_est_i);
    check("cyc_est_q", signed'(o_est_q),  m_est_q);
    check("cyc_vld",   o_vld,             m_vld);
  end

  task automatic drive(input bit stb, input int i, input int q, input int n);
    for (int k = 0; k < n; k++) begin
      strobe = stb;
      cur_i = i; cur_q = q;
      idata = 12'(i); qdata = 12'(q);
      dci = 8'(cur_dci); dcq = 8'(cur_dcq);
      @(negedge clk);
    end
  endtask

  initial begin
    int n_pulses;
    repeat (3) @(negedge clk);
    check("rst_idata", signed'(o_i), 0);
    check("rst_est_i", signed'(o_est_i), 0);
    rst_n = 1'b1;

    // Saturation with a zero estimate and the estimator off.
    cur_dci = 8;
    drive(1, -2048, 0, 1); drive(0, 0, 0, 1);
    check("sat_neg_idata", signed'(o_i), -2048);
    check("sat_neg_flag", o_sat, 1);
    cur_dci = -1;
    drive(1, 2047, 0, 1); drive(0, 0, 0, 1);
    check("sat_pos_idata", signed'(o_i), 2047);
    check("sat_pos_flag", o_sat, 1);
    cur_dci = 0;
    drive(1, 5, -7, 1); drive(0, 0, 0, 1);
    check("nosat_idata", signed'(o_i), 5);
    check("nosat_qdata", signed'(o_q), -7);
    check("nosat_flag", o_sat, 0);

    // Constant input: estimate converges in one window, then output is zeroed.
    est_en = 1'b1;
    drive(0, 0, 0, 1);
    drive(1, 100, -50, WIN);
    drive(0, 0, 0, 1);
    check("const_vld", o_vld, 1);
    check("const_est_i", signed'(o_est_i), 100);
    check("const_est_q", signed'(o_est_q), -50);
    drive(1, 100, -50, 3);
    check("const_out_fp", o_fp, 1);
    check("const_out_i", signed'(o_i), 0);
    check("const_out_q", signed'(o_q), 0);

    // Floor rounding: sum 24 -> 1, sum -24 -> -2.
    est_en = 1'b0; drive(0, 0, 0, 1);
    est_en = 1'b1; drive(0, 0, 0, 1);
    for (int k = 0; k < WIN; k++) drive(1, (k % 2) ? 2 : 1, (k % 2) ? -2 : -1, 1);
    drive(0, 0, 0, 1);
    check("floor_vld", o_vld, 1);
    check("floor_est_i", signed'(o_est_i), 1);
    check("floor_est_q", signed'(o_est_q), -2);

    // Back-to-back strobes across UPDATE: the UPDATE-cycle sample opens window 2.
    est_en = 1'b0; drive(0, 0, 0, 1);
    est_en = 1'b1; drive(0, 0, 0, 1);
    pulse_q.delete();
    for (int k = 1; k <= 40; k++) drive(1, k, -k, 1);
    check("bnd_pulses", pulse_q.size(), 2);
    if (pulse_q.size() == 2) check("bnd_gap", pulse_q[1] - pulse_q[0], WIN);
    check("bnd_est_i", signed'(o_est_i), 24);
    check("bnd_est_q", signed'(o_est_q), -25);

    // Bypass: raw data out, estimator frozen with its estimate retained.
    n_pulses = pulse_q.size();
    bypass = 1'b1; cur_dci = 20;
    drive(1, 300, -300, 1); drive(0, 0, 0, 1);
    check("byp_fp", o_fp, 1);
    check("byp_idata", signed'(o_i), 300);
    check("byp_qdata", signed'(o_q), -300);
    check("byp_sat", o_sat, 0);
    drive(1, 300, -300, WIN + 4);
    check("byp_est_i", signed'(o_est_i), 24);
    check("byp_no_pulse", pulse_q.size(), n_pulses);

    // Reset mid-window, then a fresh window of post-reset samples only.
    bypass = 1'b0; cur_dci = 0;
    drive(0, 0, 0, 1);
    drive(1, 500, -500, 9);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_idata", signed'(o_i), 0);
    check("mid_rst_fp", o_fp, 0);
    check("mid_rst_est_i", signed'(o_est_i), 0);
    check("mid_rst_est_q", signed'(o_est_q), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 1);
    drive(1, 40, 8, WIN);
    drive(0, 0, 0, 1);
    check("post_rst_vld", o_vld, 1);
    check("post_rst_est_i", signed'(o_est_i), 40);
    check("post_rst_est_q", signed'(o_est_q), 8);
    drive(0, 0, 0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
